clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, is the width of the divide-ratio and period counter.
REQ-002 Port clk, input, 1, is the single system clock; all logic SHALL be rising-edge on clk.
REQ-003 Port rst, input, 1, is the synchronous, active-high reset.
REQ-004 Port cfg_valid, input, 1, means a new divide ratio is offered.
REQ-005 Port cfg_div, input, CNT_W, is the requested ratio N; 0 means stop.
REQ-006 Port cfg_ready, output, 1, means the block can accept a ratio this cycle.
REQ-007 Port clk_en, output, 1, is a one-cycle pulse on the last cycle of each divided period.
REQ-008 Port clk_out, output, 1, is the divided square wave.
REQ-009 Port busy, output, 1, is high in RUN or PEND.
REQ-010 Port sw_count, output, 8, is the count of completed ratio switches (see Configuration).

Function
REQ-011 The FSM SHALL have three states: IDLE (stopped), RUN (dividing) and PEND (change queued).
REQ-012 A transfer occurs when cfg_valid && cfg_ready; cfg_ready = (state != PEND).
REQ-013 IDLE + transfer with N != 0: load div_q = N, cnt = 0, go to RUN next cycle.
REQ-014 IDLE + transfer with N = 0: accepted, state stays IDLE.
REQ-015 In RUN, cnt SHALL count 0..div_q-1 and wrap to 0.
REQ-016 clk_en = RUN/PEND && cnt == div_q-1.
REQ-017 clk_out = RUN/PEND && cnt < (div_q+1)>>1.
- N=1: clk_out constant 1, clk_en every cycle.
- N odd: high one cycle longer than low.
REQ-018 RUN + transfer in a non-boundary cycle (cnt != div_q-1): latch N into pend_q, go to PEND.
REQ-019 RUN + transfer in the boundary cycle: apply N at that boundary directly, without entering PEND.
REQ-020 In PEND, the current period SHALL complete unchanged; at the boundary cycle, apply pend_q.
REQ-021 Applying a ratio at a boundary: N != 0 gives div_q = N, cnt = 0, RUN; N = 0 gives IDLE, cnt = 0.
REQ-022 A divided period is never truncated or stretched; no output glitch at a ratio change.
REQ-023 In IDLE, clk_out = 0 and clk_en = 0.
REQ-024 A ratio wider than CNT_W is impossible by width; max N = 2^CNT_W - 1.

Reset
REQ-025 rst SHALL take precedence over all other inputs at any time, including mid-period and in PEND.
REQ-026 Reset values:
- state = IDLE, cnt = 0, div_q = 0, pend_q = 0, sw_count = 0.
- Outputs: clk_out = 0, clk_en = 0, busy = 0, cfg_ready = 1.
REQ-027 A transfer in the cycle rst is high SHALL be discarded.

Configuration
REQ-028 Macro CLK_DIV_CTRL_SWCNT_EN compiles in the switch counter.
- Defined: sw_count increments, saturating at 255, on every ratio application in RUN/PEND (including stop). Starts from IDLE do not count.
- Undefined: sw_count is tied to 0 and no counter register is built.

Structure
REQ-029 A shared package clk_div_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, PEND);
- the default CNT_W constant.
REQ-030 One sub-module, clk_div_core, SHALL hold cnt, div_q, clk_en and clk_out, with a load strobe and a ratio input; clk_div_ctrl holds the FSM, pend_q and the handshake.

Verification
REQ-031 Reset, then IDLE transfer with N=4 -> clk_out pattern 1,1,0,0 repeating; clk_en on every 4th cycle; busy = 1.
REQ-032 RUN with N=4, transfer N=3 at cnt=1 -> cfg_ready = 0 until the boundary; then pattern 1,1,0 repeating; sw_count = 1 (macro on).
REQ-033 RUN with N=5, transfer N=2 in the cnt=4 cycle -> no PEND; next cycles 1,0,1,0; cfg_ready stays 1.
REQ-034 RUN with N=3, transfer N=0 -> current period completes; then IDLE, clk_out = 0, busy = 0.
REQ-035 PEND queued, assert rst mid-period -> next cycle all reset values; pend_q is discarded.
REQ-036 N=1 run of 20 cycles -> clk_en = 1 and clk_out = 1 every cycle; with macro off, sw_count = 0 throughout.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider controller.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock generation for clk_div_ctrl.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio,
    output logic             clk_en,
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W:0]   half;
    logic             last;

    // One extra bit so (div_q+1) cannot overflow at the maximum ratio.
    assign half    = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;
    assign last    = (cnt == div_q - CNT_W'(1));
    assign clk_en  = run && last;
    assign clk_out = run && ({1'b0, cnt} < half);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            div_q <= ratio;
        end else if (run) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divide-ratio FSM with glitch-free ratio changes at period boundaries.
// Define CLK_DIV_CTRL_SWCNT_EN to build the ratio-switch counter.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_en,
    output logic             clk_out,
    output logic             busy,
    output logic [7:0]       sw_count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic [CNT_W-1:0] ratio;
    logic             xfer;
    logic             apply;
    logic             load;

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign xfer      = cfg_valid && cfg_ready;

    // Ratio changes while running only ever land on the last cycle of a period.
    assign apply = clk_en && ((state_q == PEND) || ((state_q == RUN) && xfer));
    assign load  = ((state_q == IDLE) && xfer) || apply;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ratio   = cfg_div;
        unique case (state_q)
            IDLE: begin
                if (xfer && cfg_div != '0) state_d = RUN;
            end
            RUN: begin
                if (xfer && clk_en) begin
                    state_d = (cfg_div == '0) ? IDLE : RUN;
                end else if (xfer) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end
            end
            PEND: begin
                ratio = pend_q;
                if (clk_en) begin
                    state_d = (pend_q == '0) ? IDLE : RUN;
                    pend_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    clk_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .run    (busy),
        .load   (load),
        .ratio  (ratio),
        .clk_en (clk_en),
        .clk_out(clk_out)
    );

`ifdef CLK_DIV_CTRL_SWCNT_EN
    logic [7:0] sw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q <= '0;
        end else if (apply && sw_q != 8'hFF) begin
            sw_q <= sw_q + 8'd1;
        end
    end

    assign sw_count = sw_q;
`else
    assign sw_count = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized and directed bench for clk_div_ctrl against a period-level model.
module tb_clk_div_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         clk_en;
    logic         clk_out;
    logic         busy;
    logic [7:0]   sw_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: current ratio (0 = stopped), phase within period, queued ratio.
    int m_n   = 0;
    int m_ph  = 0;
    int m_pnd = -1;
    int m_sw  = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .clk_en   (clk_en),
        .clk_out  (clk_out),
        .busy     (busy),
        .sw_count (sw_count)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_apply(input int n);
        m_n  = n;
        m_ph = 0;
`ifdef CLK_DIV_CTRL_SWCNT_EN
        if (m_sw < 255) m_sw++;
`endif
    endtask

    task automatic m_clock(input bit v, input int d, input bit r);
        bit xfer;
        bit last;
        if (r) begin
            m_n = 0; m_ph = 0; m_pnd = -1; m_sw = 0;
            return;
        end
        xfer = v && (m_pnd < 0);
        if (m_n == 0) begin
            if (xfer && d != 0) begin
                m_n  = d;
                m_ph = 0;
            end
            return;
        end
        last = (m_ph == m_n - 1);
        if (m_pnd >= 0) begin
            if (last) begin
                m_apply(m_pnd);
                m_pnd = -1;
            end else begin
                m_ph++;
            end
        end else if (xfer) begin
            if (last) begin
                m_apply(d);
            end else begin
                m_pnd = d;
                m_ph++;
            end
        end else begin
            m_ph = last ? 0 : m_ph + 1;
        end
    endtask

    task automatic step(input bit v, input int d, input bit r);
        cfg_valid = v;
        cfg_div   = W'(d);
        rst       = r;
        #3;
        chk("clk_out", int'(clk_out), int'(m_n != 0 && 2 * m_ph < m_n));
        chk("clk_en", int'(clk_en), int'(m_n != 0 && m_ph == m_n - 1));
        chk("busy", int'(busy), int'(m_n != 0));
        chk("cfg_ready", int'(cfg_ready), int'(m_pnd < 0));
        chk("sw_count", int'(sw_count), m_sw);
        @(posedge clk);
        m_clock(v, d, r);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic wait_ph(input int p);
        int reached;
        reached = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_n != 0 && m_ph == p) begin
                reached = 1;
                break;
            end
            step(1'b0, 0, 1'b0);
        end
        chk("wait_bound", reached, 1);
    endtask

    initial begin
        cfg_valid = 1'b0;
        cfg_div   = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        step(1'b1, 4, 1'b0);
        idle(12);

        wait_ph(1);
        step(1'b1, 3, 1'b0);
        step(1'b1, 7, 1'b0);
        step(1'b1, 9, 1'b0);
        idle(9);

        step(1'b1, 5, 1'b0);
        wait_ph(4);
        step(1'b1, 5, 1'b0);
        wait_ph(4);
        step(1'b1, 2, 1'b0);
        idle(6);

        step(1'b1, 3, 1'b0);
        wait_ph(0);
        step(1'b1, 0, 1'b0);
        idle(6);

        step(1'b1, 6, 1'b0);
        wait_ph(1);
        step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b1, 4, 1'b1);
        idle(8);

        step(1'b1, 1, 1'b0);
        idle(20);
        step(1'b1, 0, 1'b0);
        idle(3);

        step(1'b1, 255, 1'b0);
        idle(520);

        for (int i = 0; i < 4000; i++) begin
            bit v;
            bit r;
            int d;
            v = ($urandom_range(0, 99) < 25);
            r = ($urandom_range(0, 999) < 4);
            d = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(0, 7);
            step(v, d, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
